button_bounce_gen: RTL and testbench



---
 rtl/button_bounce_gen_pkg.sv | 16 +
 rtl/button_bounce_gen_if.sv | 22 ++
 rtl/button_bounce_gen_lfsr16.sv | 27 ++
 rtl/button_bounce_gen.sv | 157 +++++++++++++++
 tb/tb_button_bounce_gen.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/button_bounce_gen_pkg.sv
// Shared types and helpers for the button bounce emulator and its LFSR.
package bounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        HOLD
    } bounce_state_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    function automatic int us_to_cycles(input int us, input int freq);
        return us * freq;
    endfunction

endpackage

// File: rtl/button_bounce_gen_if.sv
// Request handshake and emulated button line between a requester and button_bounce_gen.
interface button_bounce_gen_if;

    logic       req_valid;
    logic       req_level;
    logic       req_ready;
    logic       btn_out;
    logic       busy;
    logic       done;
    logic [7:0] edge_cnt;

    modport master (
        output req_valid, req_level,
        input  req_ready, btn_out, busy, done, edge_cnt
    );

    modport slave (
        input  req_valid, req_level,
        output req_ready, btn_out, busy, done, edge_cnt
    );

endinterface

// File: rtl/button_bounce_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift); a zero seed is replaced by 1 so it never locks up.
module lfsr16
    import bounce_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [OUT_W-1:0] lfsr
);

    localparam logic [15:0] SEED_FIX = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SEED_FIX;
        end else begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_MASK : 16'h0000);
        end
    end

    assign lfsr = state[OUT_W-1:0];

endmodule

// File: rtl/button_bounce_gen.sv
// Mechanical-button emulator: pseudo-random bounce burst, then a stable hold at the requested level.
// Define BOUNCE_GEN_GLITCH_EN to add a one-cycle inversion mid-hold after a bounce (needs HOLD_CYC >= 2).
module button_bounce_gen
    import bounce_pkg::*;
#(
    parameter int          FREQ      = 50,
    parameter int          BOUNCE_US = 5000,
    parameter int          HOLD_US   = 30000,
    parameter int          N         = 20,
    parameter int          SEG_W     = 10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst_n,
    button_bounce_gen_if.slave  bus
);

    localparam int BOUNCE_CYC = us_to_cycles(BOUNCE_US, FREQ);
    localparam int HOLD_CYC   = us_to_cycles(HOLD_US, FREQ);

    localparam logic [N-1:0]     WIN_LAST  = N'(BOUNCE_CYC - 1);
    localparam logic [N-1:0]     HOLD_LAST = N'(HOLD_CYC - 1);
    localparam logic [N-1:0]     CNT_ONE   = N'(1);
    localparam logic [SEG_W-1:0] SEG_ONE   = SEG_W'(1);

    bounce_state_t    state, state_n;
    logic             btn_q, btn_n;
    logic             lvl_q, lvl_n;
    logic             done_q, done_n;
    logic [7:0]       edge_q, edge_n;
    logic [N-1:0]     win_q, win_n;
    logic [N-1:0]     hold_q, hold_n;
    logic [SEG_W-1:0] seg_q, seg_n;
    logic [SEG_W-1:0] lfsr_seg;

`ifdef BOUNCE_GEN_GLITCH_EN
    localparam logic [N-1:0] GLITCH_PRE = N'(HOLD_CYC / 2 - 1);
    logic from_bounce_q, from_bounce_n;
`endif

    lfsr16 #(
        .SEED  (LFSR_SEED),
        .OUT_W (SEG_W)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .lfsr  (lfsr_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            btn_q  <= 1'b1;
            lvl_q  <= 1'b1;
            done_q <= 1'b0;
            edge_q <= 8'd0;
            win_q  <= '0;
            hold_q <= '0;
            seg_q  <= '0;
        end else begin
            state  <= state_n;
            btn_q  <= btn_n;
            lvl_q  <= lvl_n;
            done_q <= done_n;
            edge_q <= edge_n;
            win_q  <= win_n;
            hold_q <= hold_n;
            seg_q  <= seg_n;
        end
    end

`ifdef BOUNCE_GEN_GLITCH_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            from_bounce_q <= 1'b0;
        end else begin
            from_bounce_q <= from_bounce_n;
        end
    end
`endif

    // The window end forces the settled level and wins over a segment toggle in the same cycle.
    always_comb begin
        state_n = state;
        btn_n   = btn_q;
        lvl_n   = lvl_q;
        done_n  = 1'b0;
        edge_n  = edge_q;
        win_n   = win_q;
        hold_n  = hold_q;
        seg_n   = seg_q;
`ifdef BOUNCE_GEN_GLITCH_EN
        from_bounce_n = from_bounce_q;
`endif
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    lvl_n = bus.req_level;
                    if (bus.req_level != btn_q) begin
                        state_n = BOUNCE;
                        btn_n   = ~btn_q;
                        edge_n  = 8'd1;
                        win_n   = '0;
                        seg_n   = lfsr_seg;
                    end else begin
                        state_n = HOLD;
                        edge_n  = 8'd0;
                        hold_n  = '0;
`ifdef BOUNCE_GEN_GLITCH_EN
                        from_bounce_n = 1'b0;
`endif
                    end
                end
            end
            BOUNCE: begin
                win_n = win_q + CNT_ONE;
                if (win_q == WIN_LAST) begin
                    state_n = HOLD;
                    btn_n   = lvl_q;
                    hold_n  = '0;
`ifdef BOUNCE_GEN_GLITCH_EN
                    from_bounce_n = 1'b1;
`endif
                end else if (seg_q == '0) begin
                    btn_n  = ~btn_q;
                    edge_n = (edge_q == 8'hFF) ? edge_q : edge_q + 8'd1;
                    seg_n  = lfsr_seg;
                end else begin
                    seg_n = seg_q - SEG_ONE;
                end
            end
            HOLD: begin
                hold_n = hold_q + CNT_ONE;
                btn_n  = lvl_q;
`ifdef BOUNCE_GEN_GLITCH_EN
                if (from_bounce_q && hold_q == GLITCH_PRE) begin
                    btn_n = ~lvl_q;
                end
`endif
                if (hold_q == HOLD_LAST) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.btn_out   = btn_q;
    assign bus.done      = done_q;
    assign bus.edge_cnt  = edge_q;

endmodule

// File: tb/tb_button_bounce_gen.sv
// Self-checking bench for button_bounce_gen: randomized requests against a segment-list reference model.
module tb_button_bounce_gen;
    import bounce_pkg::*;

    localparam int B    = 100;
    localparam int H    = 50;
    localparam int SEG  = 3;
    localparam int B2   = 1000;
    localparam int H2   = 10;
    localparam int SEG2 = 1;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef BOUNCE_GEN_GLITCH_EN
    localparam bit GLITCH = 1'b1;
`else
    localparam bit GLITCH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    button_bounce_gen_if bus ();
    button_bounce_gen_if bus2 ();

    button_bounce_gen #(
        .FREQ(1), .BOUNCE_US(B), .HOLD_US(H), .N(20), .SEG_W(SEG), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    button_bounce_gen #(
        .FREQ(1), .BOUNCE_US(B2), .HOLD_US(H2), .N(20), .SEG_W(SEG2), .LFSR_SEED(SEED)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    int checks = 0;
    int errors = 0;
    int last_exp_cnt = 0;
    int first_cnt = 0;
    logic cur_btn = 1'b1;
    logic [15:0] m_lfsr = 16'h0000;

    // Galois right-shift step with the B400 feedback taps.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    always @(posedge clk) m_lfsr <= !rst_n ? SEED : lfsr_next(m_lfsr);

    // Toggle events at offsets 0, then each segment (lfsr_low+1 cycles) later, inside the window.
    function automatic int count_toggles(input logic [15:0] l0, input int seg_w,
                                         input int upto, input int win);
        logic [15:0] l;
        int e, n, len;
        l = l0;
        e = 0;
        n = 0;
        while (e <= upto && e < win) begin
            n++;
            len = int'(l & ((16'd1 << seg_w) - 16'd1)) + 1;
            for (int k = 0; k < len; k++) l = lfsr_next(l);
            e += len;
        end
        return n;
    endfunction

    task automatic run_request(input logic level, input int mode);
        logic [15:0] l0;
        bit bounce;
        int total, ho, exp_cnt;
        logic exp_btn;
        logic [3:0] got, exp_v;
        l0 = m_lfsr;
        bounce = (level != cur_btn);
        total = bounce ? B + H : H;
        bus.req_valid = 1'b1;
        bus.req_level = level;
        for (int o = 0; o <= total; o++) begin
            @(posedge clk); #1;
            if (bounce && o < B) begin
                exp_btn = cur_btn ^ (count_toggles(l0, SEG, o, B) % 2 == 1);
            end else begin
                ho = bounce ? o - B : o;
                exp_btn = level ^ (GLITCH && bounce && ho == H / 2);
            end
            exp_v = {exp_btn, (o < total), (o == total), (o == total)};
            got = {bus.btn_out, bus.busy, bus.req_ready, bus.done};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("[TB] FAIL req_cycle%0d lvl%0d {btn,busy,ready,done}: got %b expected %b",
                         o, level, got, exp_v);
            end
            if (o == total) begin
                bus.req_valid = (mode == 2);
            end else if (mode == 1) begin
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_level = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                bus.req_level = 1'($urandom_range(0, 1));
            end else begin
                bus.req_valid = 1'b0;
            end
        end
        exp_cnt = 0;
        if (bounce) begin
            exp_cnt = count_toggles(l0, SEG, B - 1, B);
            if (exp_cnt > 255) exp_cnt = 255;
        end
        last_exp_cnt = exp_cnt;
        checks++;
        if (bus.edge_cnt !== 8'(exp_cnt)) begin
            errors++;
            $display("[TB] FAIL edge_cnt lvl%0d: got %0d expected %0d", level, bus.edge_cnt, exp_cnt);
        end
        cur_btn = level;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.btn_out, bus.busy, bus.req_ready, bus.done} !== {cur_btn, 3'b010}) begin
                errors++;
                $display("[TB] FAIL idle {btn,busy,ready,done}: got %b expected %b",
                         {bus.btn_out, bus.busy, bus.req_ready, bus.done}, {cur_btn, 3'b010});
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if ({bus.btn_out, bus.busy, bus.req_ready, bus.done, bus.edge_cnt} !== {4'b1010, 8'd0}) begin
            errors++;
            $display("[TB] FAIL %s dut {btn,busy,ready,done,edge}: got %b expected %b", tag,
                     {bus.btn_out, bus.busy, bus.req_ready, bus.done, bus.edge_cnt}, {4'b1010, 8'd0});
        end
        checks++;
        if ({bus2.btn_out, bus2.busy, bus2.req_ready, bus2.done, bus2.edge_cnt} !== {4'b1010, 8'd0}) begin
            errors++;
            $display("[TB] FAIL %s dut_sat {btn,busy,ready,done,edge}: got %b expected %b", tag,
                     {bus2.btn_out, bus2.busy, bus2.req_ready, bus2.done, bus2.edge_cnt}, {4'b1010, 8'd0});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        cur_btn = 1'b1;
    endtask

    task automatic test_press();
        idle_cycles(2);
        run_request(1'b0, 0);
        first_cnt = last_exp_cnt;
        run_request(1'b1, 0);
    endtask

    task automatic test_same_level();
        run_request(1'b1, 0);
        run_request(1'b1, 1);
        idle_cycles(3);
    endtask

    task automatic test_busy_noise();
        run_request(1'b0, 1);
        run_request(1'b0, 1);
        run_request(1'b1, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) run_request(~cur_btn, 2);
        run_request(~cur_btn, 0);
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_bounce();
        bus.req_valid = 1'b1;
        bus.req_level = ~cur_btn;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("mid_reset");
        rst_n = 1'b1;
        cur_btn = 1'b1;
        idle_cycles(2);
        run_request(1'b0, 0);
        checks++;
        if (bus.edge_cnt !== 8'(first_cnt)) begin
            errors++;
            $display("[TB] FAIL lfsr_restart edge_cnt: got %0d expected %0d", bus.edge_cnt, first_cnt);
        end
    endtask

    task automatic test_glitch();
        run_request(~cur_btn, 0);
        run_request(cur_btn, 0);
    endtask

    task automatic test_saturation();
        logic [15:0] l0;
        int exp99, exp_all;
        l0 = m_lfsr;
        exp99 = count_toggles(l0, SEG2, 99, B2);
        exp_all = count_toggles(l0, SEG2, B2 - 1, B2);
        if (exp_all > 255) exp_all = 255;
        bus2.req_valid = 1'b1;
        bus2.req_level = 1'b0;
        for (int o = 0; o <= B2 + H2; o++) begin
            @(posedge clk); #1;
            bus2.req_valid = 1'b0;
            if (o == 99) begin
                checks++;
                if (bus2.edge_cnt !== 8'(exp99)) begin
                    errors++;
                    $display("[TB] FAIL sat_window100 edge_cnt: got %0d expected %0d", bus2.edge_cnt, exp99);
                end
            end
            if (o == B2 + H2) begin
                checks++;
                if ({bus2.btn_out, bus2.busy, bus2.done, bus2.edge_cnt} !== {3'b001, 8'(exp_all)}) begin
                    errors++;
                    $display("[TB] FAIL sat_done {btn,busy,done,edge}: got %b expected %b",
                             {bus2.btn_out, bus2.busy, bus2.done, bus2.edge_cnt}, {3'b001, 8'(exp_all)});
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_level = 1'b1;
        bus2.req_valid = 1'b0;
        bus2.req_level = 1'b1;
        test_reset();
        test_press();
        test_same_level();
        test_busy_noise();
        test_back_to_back();
        test_reset_mid_bounce();
        test_glitch();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
